// File: rtl/sel_mux_pkg.sv
// Shared constants and helpers for the sel_mux_pipe channel selector.
package sel_mux_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_NUM_IN = 8;

    // Select width for a given channel count; NUM_IN is at least 2.
    function automatic int sel_width(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-channel picker: first valid channel strictly above cur, with
// wrap-around; cur itself is the last candidate, and cur is kept when none is valid.
module rr_next_sel
    import sel_mux_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] valid,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next
);

    logic found;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        next  = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (!found && valid[j] && (j == (int'(cur) + k) % NUM_IN)) begin
                    next  = SEL_W'(j);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N:1 valid/ready channel selector with one output stage.
// Define SEL_MUX_RR_EN to replace the loaded select with round-robin arbitration.
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_load,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             can_accept;
    logic             take;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_valid = in_valid[i];
            end
        end
    end

    // The output stage accepts when empty or when its word drains this cycle.
    assign can_accept = !out_valid || out_ready;
    assign take       = sel_valid && can_accept && rst_n;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = rst_n && can_accept && (cur_sel == SEL_W'(i));
        end
    end

`ifdef SEL_MUX_RR_EN
    logic [SEL_W-1:0] rr_next;
    logic             unused_sel_inputs;

    assign unused_sel_inputs = ^{sel, sel_load};

    rr_next_sel #(.NUM_IN(NUM_IN)) u_rr_next_sel (
        .valid (in_valid),
        .cur   (cur_sel),
        .next  (rr_next)
    );
`else
    logic sel_in_range;

    assign sel_in_range = int'(sel) < NUM_IN;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            cur_sel   <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (take) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef SEL_MUX_RR_EN
            // Move on after a transfer, or away from an idle channel.
            if (take || !sel_valid) begin
                cur_sel <= rr_next;
            end
`else
            // A coinciding transfer already used the old cur_sel above.
            if (sel_load) begin
                if (sel_in_range) begin
                    cur_sel <= sel;
                end else begin
                    sel_err <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed self-checking bench for sel_mux_pipe (select mode, or round-robin
// when SEL_MUX_RR_EN is defined).
module tb_sel_mux_pipe;

`ifdef SEL_MUX_RR_EN
    localparam int N = 8;
`else
    localparam int N = 6;
`endif
    localparam int W  = 16;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   sel;
    logic            sel_load;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   cur_sel;
    logic            sel_err;

    int total = 0;
    int bad   = 0;

    sel_mux_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_load  (sel_load),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_rdy;
        rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; sel_load = 1'b0; out_ready = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        total++; if (cur_sel !== '0) begin bad++; $display("FAIL reset_cur_sel got=%0d exp=0", cur_sel); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
        total++; if (in_ready !== '0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        #1;
        exp_rdy = 1;
        total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=%b", in_ready, exp_rdy); end
    endtask

`ifdef SEL_MUX_RR_EN
    task automatic test_round_robin();
        logic [W-1:0] exp_seq [6];
        int got = 0;
        exp_seq = '{16'h0100, 16'h0400, 16'h0600, 16'h0100, 16'h0400, 16'h0600};
        for (int i = 0; i < N; i++) set_ch(i, W'(i * 256));
        in_valid = 8'b0101_0010;
        out_ready = 1'b1;
        sel = 3'd7; sel_load = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            step();
            if (out_valid) begin
                total++; if (out_data !== exp_seq[got]) begin bad++; $display("FAIL rr_order[%0d] got=%h exp=%h", got, out_data, exp_seq[got]); end
                got++;
            end
        end
        total++; if (got != 6) begin bad++; $display("FAIL rr_timeout words got=%0d exp=6", got); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rr_sel_err got=%b exp=0", sel_err); end
        in_valid = '0; sel_load = 1'b0;
        step();
    endtask
`else
    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 16'hA000 + 16'(k));
            in_valid = 6'b000001;
            #1;
            total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, in_ready[0]); end
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(k)) begin bad++; $display("FAIL b2b_word[%0d] got=%b/%h exp=1/%h", k, out_valid, out_data, 16'hA000 + 16'(k)); end
        end
        in_valid = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load_transfer();
        sel = 3'd3; sel_load = 1'b1;
        set_ch(3, 16'hBEEF); in_valid = 6'b001000; out_ready = 1'b1;
        step();
        sel_load = 1'b0;
        total++; if (cur_sel !== 3'd3) begin bad++; $display("FAIL load_cur_sel got=%0d exp=3", cur_sel); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL load_no_early_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 6'b001000) begin bad++; $display("FAIL load_in_ready got=%b exp=001000", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin bad++; $display("FAIL load_word got=%b/%h exp=1/beef", out_valid, out_data); end
        in_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        set_ch(3, 16'h3000); in_valid = 6'b001000; out_ready = 1'b0;
        step();
        set_ch(3, 16'h3001);
        total++; if (out_valid !== 1'b1 || out_data !== 16'h3000) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/3000", out_valid, out_data); end
        for (int c = 0; c < 5; c++) begin
            total++; if (in_ready[3] !== 1'b0) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", c, in_ready[3]); end
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 16'h3000) begin bad++; $display("FAIL bp_frozen[%0d] got=%b/%h exp=1/3000", c, out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready[3] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready[3]); end
        step();
        set_ch(3, 16'h3002);
        total++; if (out_valid !== 1'b1 || out_data !== 16'h3001) begin bad++; $display("FAIL bp_next got=%b/%h exp=1/3001", out_valid, out_data); end
        step();
        in_valid = '0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h3002) begin bad++; $display("FAIL bp_last got=%b/%h exp=1/3002", out_valid, out_data); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sel_change();
        out_ready = 1'b1;
        set_ch(3, 16'h1111); set_ch(5, 16'h5555); in_valid = 6'b101000;
        sel = 3'd5; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        set_ch(3, 16'h2222);
        total++; if (out_valid !== 1'b1 || out_data !== 16'h1111) begin bad++; $display("FAIL selchg_old_word got=%b/%h exp=1/1111", out_valid, out_data); end
        total++; if (cur_sel !== 3'd5) begin bad++; $display("FAIL selchg_cur_sel got=%0d exp=5", cur_sel); end
        total++; if (in_ready !== 6'b100000) begin bad++; $display("FAIL selchg_in_ready got=%b exp=100000", in_ready); end
        step();
        in_valid = 6'b001000;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h5555) begin bad++; $display("FAIL selchg_new_word got=%b/%h exp=1/5555", out_valid, out_data); end
        step();
        in_valid = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL selchg_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_sel_err();
        sel = 3'd7; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL selerr_set got=%b exp=1", sel_err); end
        total++; if (cur_sel !== 3'd5) begin bad++; $display("FAIL selerr_cur_sel got=%0d exp=5", cur_sel); end
        sel = 3'd2; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step(); step();
        total++; if (cur_sel !== 3'd2) begin bad++; $display("FAIL selerr_reload got=%0d exp=2", cur_sel); end
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL selerr_sticky got=%b exp=1", sel_err); end
    endtask

    task automatic test_reset_pending();
        set_ch(2, 16'hABCD); in_valid = 6'b000100; out_ready = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin bad++; $display("FAIL rstp_pending got=%b/%h exp=1/abcd", out_valid, out_data); end
        rst_n = 1'b0; sel = 3'd4; sel_load = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== '0) begin bad++; $display("FAIL rstp_in_ready got=%b exp=0", in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin bad++; $display("FAIL rstp_out got=%b/%h exp=0/0000", out_valid, out_data); end
        total++; if (cur_sel !== 3'd0) begin bad++; $display("FAIL rstp_cur_sel got=%0d exp=0", cur_sel); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rstp_sel_err got=%b exp=0", sel_err); end
        rst_n = 1'b1; sel_load = 1'b0; in_valid = '0;
        step();
        total++; if (sel_err !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rstp_after got=%b/%b exp=0/0", sel_err, out_valid); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SEL_MUX_RR_EN
        test_round_robin();
`else
        test_back_to_back();
        test_load_transfer();
        test_backpressure();
        test_sel_change();
        test_sel_err();
        test_reset_pending();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sel_mux_pipe.md
SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 8, input channel count, range 2..32.
REQ-003 SHALL have localparam SEL_W = $clog2(NUM_IN), select width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have port in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  in  NUM_IN  per-channel valid.
REQ-009 SHALL have port in_ready  out  NUM_IN  per-channel ready.
REQ-010 SHALL have port sel  in  SEL_W  requested channel.
REQ-011 SHALL have port sel_load  in  1  capture sel into the active-select register.
REQ-012 SHALL have port out_data  out  WIDTH  registered selected data.
REQ-013 SHALL have port out_valid  out  1  out_data holds an untaken word.
REQ-014 SHALL have port out_ready  in  1  downstream accepts the word.
REQ-015 SHALL have port cur_sel  out  SEL_W  active-select register.
REQ-016 SHALL have port sel_err  out  1  sticky flag for an out-of-range sel load.

Function
REQ-017 SHALL register sel into cur_sel on any edge with sel_load=1 and sel<NUM_IN; the new value governs selection from the following cycle.
REQ-018 SHALL ignore sel_load with sel>=NUM_IN: cur_sel is unchanged and sel_err is set to 1 until reset.
REQ-019 SHALL drive in_ready[i] = (i==cur_sel) && (!out_valid || out_ready); all other in_ready bits SHALL be 0.
REQ-020 SHALL transfer when in_valid[cur_sel] && in_ready[cur_sel]: out_data <= channel data, out_valid <= 1; latency is 1 cycle.
REQ-021 SHALL clear out_valid when out_ready=1 with no transfer in the same cycle; a simultaneous drain and transfer SHALL keep out_valid=1 with the new data (full throughput, 1 word/cycle).
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL use the old cur_sel for a transfer when sel_load coincides with it; no word is lost or duplicated across a select change.
REQ-024 SHALL never drop or reorder data on unselected channels; they stall with in_ready=0.

Reset
REQ-025 SHALL, with rst_n=0 at an edge, set out_valid=0, out_data=0, cur_sel=0 and sel_err=0, overriding sel_load and any transfer in that cycle.
REQ-026 SHALL hold in_ready=0 on all channels while rst_n=0; a pending output word is discarded.

Configuration
REQ-027 SHALL compile round-robin mode only when macro SEL_MUX_RR_EN is defined.
REQ-028 SHALL, with SEL_MUX_RR_EN defined, ignore sel/sel_load; after each transfer cur_sel advances to the next valid channel above it, with wrap-around; with no valid channel cur_sel holds; sel_err stays 0.
REQ-029 SHALL, without SEL_MUX_RR_EN, behave as REQ-017..REQ-018 with no arbiter logic synthesised.

Structure
REQ-030 SHALL place the default WIDTH/NUM_IN constants and the SEL_W computation function in shared package sel_mux_pkg.
REQ-031 SHALL implement round-robin selection in sub-module rr_next_sel (inputs: valid vector and current index; output: next index), instantiated only under SEL_MUX_RR_EN.

Verification
REQ-032 SHALL cover: reset, then sel_load with sel=3 and in_valid[3]=1 carrying data 0xBEEF, out_ready=1 -> out_valid=1 with out_data=0xBEEF two edges after the load.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with channel 3 streaming -> out_data is frozen, in_ready[3]=0, and no word is lost when out_ready rises.
REQ-034 SHALL cover: sel_load with sel=5 in the same cycle as a channel-3 transfer of 0x1111 -> 0x1111 is output, and the next word comes from channel 5.
REQ-035 SHALL cover: NUM_IN=6 with sel_load and sel=7 -> sel_err=1, cur_sel unchanged; sel_err persists until rst_n=0.
REQ-036 SHALL cover: rst_n=0 while out_valid=1 -> out_valid=0, out_data=0 and cur_sel=0 at the next edge.
REQ-037 SHALL cover, with SEL_MUX_RR_EN defined: channels 1, 4 and 6 always valid and out_ready=1 -> output order is 1,4,6,1,4,6.
